// File: rtl/demux_1xn_stream_if.sv
// Port bundle for demux_1xn_stream: one upstream beat stream (data, select, broadcast)
// fanned out to N registered downstream slots with per-channel valid/ready.
interface demux_1xn_stream_if #(
  parameter int WIDTH = 2,
  parameter int N     = 4
);
  localparam int SELW = $clog2(N);

  logic [WIDTH-1:0]        in_data;
  logic [SELW-1:0]         in_sel;
  logic                    in_bcast;
  logic                    in_valid;
  logic                    in_ready;
  logic [N-1:0][WIDTH-1:0] out_data;
  logic [N-1:0]            out_valid;
  logic [N-1:0]            out_ready;
  logic                    sel_err;

  modport master (
    output in_data, in_sel, in_bcast, in_valid, out_ready,
    input  in_ready, out_data, out_valid, sel_err
  );

  modport slave (
    input  in_data, in_sel, in_bcast, in_valid, out_ready,
    output in_ready, out_data, out_valid, sel_err
  );
endinterface

// File: rtl/demux_1xn_stream.sv
// 1:N stream demux, one registered slot per channel (accept at edge k -> visible after k); in_ready
// is comb per target slot, broadcast is all-or-nothing. DEMUX_ZERO_IDLE_EN zeroes idle out_data.
module demux_1xn_stream #(
  parameter int WIDTH = 2,
  parameter int N     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  demux_1xn_stream_if.slave  bus
);
  localparam int SELW = $clog2(N);

  logic [N-1:0][WIDTH-1:0] data_q;
  logic [N-1:0]            valid_q;
  logic                    err_q;

  logic [N-1:0] can_load;
  logic [N-1:0] sel_hit;
  logic [N-1:0] load;
  logic         sel_ok;
  logic         in_ready_c;
  logic         accept;
  logic         drop;

  // One-hot decode; an out-of-range select simply produces no hit.
  always_comb begin
    sel_hit = '0;
    for (int i = 0; i < N; i++) begin
      sel_hit[i] = (bus.in_sel == SELW'(i));
    end
  end

  assign can_load = ~valid_q | bus.out_ready;
  assign sel_ok   = |sel_hit;

  always_comb begin
    in_ready_c = 1'b1;
    if (bus.in_bcast) begin
      in_ready_c = &can_load;
    end else if (sel_ok) begin
      in_ready_c = |(can_load & sel_hit);
    end
  end

  assign accept = bus.in_valid & in_ready_c;
  assign drop   = accept & ~bus.in_bcast & ~sel_ok;

  always_comb begin
    load = '0;
    if (accept) begin
      load = bus.in_bcast ? {N{1'b1}} : sel_hit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= drop;
      for (int i = 0; i < N; i++) begin
        if (load[i]) begin
          data_q[i]  <= bus.in_data;
          valid_q[i] <= 1'b1;
        end else if (valid_q[i] && bus.out_ready[i]) begin
          valid_q[i] <= 1'b0;
`ifdef DEMUX_ZERO_IDLE_EN
          data_q[i]  <= '0;
`endif
        end
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.sel_err   = err_q;

endmodule

// File: tb/tb_demux_1xn_stream.sv
// Bench for demux_1xn_stream: directed vector table and corner sequences on N=4 and N=3 instances,
// then randomized traffic against an occupancy-based reference model.
module tb_demux_1xn_stream;
`ifdef DEMUX_ZERO_IDLE_EN
  localparam bit ZI = 1'b1;
`else
  localparam bit ZI = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  demux_1xn_stream_if #(.WIDTH(8), .N(4)) b4 ();
  demux_1xn_stream_if #(.WIDTH(8), .N(3)) b3 ();

  demux_1xn_stream #(.WIDTH(8), .N(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  demux_1xn_stream #(.WIDTH(8), .N(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3));

  int n_pass = 0;
  int n_chk  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", nm, act, exp);
  endtask

  // Reference model: each channel is a single-entry buffer (occupied flag + held byte).
  bit         occ  [2][4];
  logic [7:0] held [2][4];
  bit         err  [2];

  task automatic m_reset();
    for (int d = 0; d < 2; d++) begin
      err[d] = 1'b0;
      for (int c = 0; c < 4; c++) begin
        occ[d][c]  = 1'b0;
        held[d][c] = 8'h00;
      end
    end
  endtask

  function automatic bit m_ready(input int d, input int n, input bit bc, input int sel,
                                 input logic [3:0] ordy);
    if (bc) begin
      for (int c = 0; c < n; c++) if (occ[d][c] && !ordy[c]) return 1'b0;
      return 1'b1;
    end
    if (sel >= n) return 1'b1;
    return !occ[d][sel] || ordy[sel];
  endfunction

  task automatic m_step(input int d, input int n, input bit v, input bit bc, input int sel,
                        input logic [7:0] dat, input logic [3:0] ordy);
    bit acc;
    acc = v && m_ready(d, n, bc, sel, ordy);
    for (int c = 0; c < n; c++) if (occ[d][c] && ordy[c]) occ[d][c] = 1'b0;
    err[d] = acc && !bc && (sel >= n);
    if (acc) begin
      for (int c = 0; c < n; c++) begin
        if (bc || c == sel) begin
          occ[d][c]  = 1'b1;
          held[d][c] = dat;
        end
      end
    end
  endtask

  function automatic logic [31:0] m_od(input int d, input int n);
    logic [31:0] r = '0;
    for (int c = 0; c < n; c++) r[c*8 +: 8] = (occ[d][c] || !ZI) ? held[d][c] : 8'h00;
    return r;
  endfunction

  function automatic logic [31:0] m_ov(input int d, input int n);
    logic [31:0] r = '0;
    for (int c = 0; c < n; c++) r[c] = occ[d][c];
    return r;
  endfunction

  typedef struct {
    bit          v;
    bit          bc;
    logic [1:0]  sel;
    logic [7:0]  dat;
    logic [3:0]  ordy;
    bit          rdy;
    logic [3:0]  ov;
    logic [31:0] od;
  } vec_t;

  function automatic vec_t mk(input bit v, input bit bc, input logic [1:0] sel, input logic [7:0] dat,
                              input logic [3:0] ordy, input bit rdy, input logic [3:0] ov,
                              input logic [31:0] od_zi, input logic [31:0] od_hold);
    vec_t r;
    r.v = v; r.bc = bc; r.sel = sel; r.dat = dat; r.ordy = ordy;
    r.rdy = rdy; r.ov = ov; r.od = ZI ? od_zi : od_hold;
    return r;
  endfunction

  function automatic logic [3:0] rnd_ready(input int bits);
    logic [3:0] r = '0;
    for (int c = 0; c < bits; c++) r[c] = ($urandom_range(0, 3) != 0);
    return r;
  endfunction

  vec_t tbl [13];

  initial begin
    b4.in_data = '0; b4.in_sel = '0; b4.in_bcast = 1'b0; b4.in_valid = 1'b0; b4.out_ready = '1;
    b3.in_data = '0; b3.in_sel = '0; b3.in_bcast = 1'b0; b3.in_valid = 1'b0; b3.out_ready = '1;

    tbl[0]  = mk(1, 0, 0, 8'h11, 4'hF, 1, 4'b0001, 32'h00000011, 32'h00000011);
    tbl[1]  = mk(1, 0, 1, 8'h22, 4'hF, 1, 4'b0010, 32'h00002200, 32'h00002211);
    tbl[2]  = mk(1, 0, 2, 8'h33, 4'hF, 1, 4'b0100, 32'h00330000, 32'h00332211);
    tbl[3]  = mk(1, 0, 3, 8'h44, 4'hF, 1, 4'b1000, 32'h44000000, 32'h44332211);
    tbl[4]  = mk(0, 0, 0, 8'h00, 4'hF, 1, 4'b0000, 32'h00000000, 32'h44332211);
    tbl[5]  = mk(1, 0, 2, 8'hA5, 4'hB, 1, 4'b0100, 32'h00A50000, 32'h44A52211);
    tbl[6]  = mk(1, 0, 2, 8'h5A, 4'hB, 0, 4'b0100, 32'h00A50000, 32'h44A52211);
    tbl[7]  = mk(1, 0, 2, 8'h5A, 4'hF, 1, 4'b0100, 32'h005A0000, 32'h445A2211);
    tbl[8]  = mk(0, 0, 0, 8'h00, 4'hF, 1, 4'b0000, 32'h00000000, 32'h445A2211);
    tbl[9]  = mk(1, 0, 1, 8'h77, 4'hD, 1, 4'b0010, 32'h00007700, 32'h445A7711);
    tbl[10] = mk(1, 1, 0, 8'hFF, 4'hD, 0, 4'b0010, 32'h00007700, 32'h445A7711);
    tbl[11] = mk(1, 1, 0, 8'hFF, 4'hF, 1, 4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF);
    tbl[12] = mk(0, 0, 0, 8'h00, 4'hF, 1, 4'b0000, 32'h00000000, 32'hFFFFFFFF);

    // Reset state, with a pending beat on the input to show readiness while empty.
    repeat (2) @(posedge clk);
    #1;
    b4.in_valid = 1'b1;
    #1;
    check("rst_ov4", 32'(b4.out_valid), 32'h0);
    check("rst_od4", 32'(b4.out_data), 32'h0);
    check("rst_err4", 32'(b4.sel_err), 32'h0);
    check("rst_ov3", 32'(b3.out_valid), 32'h0);
    check("rst_rdy4", 32'(b4.in_ready), 32'h1);
    b4.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vector table on the N=4 instance.
    for (int i = 0; i < 13; i++) begin
      b4.in_valid = tbl[i].v; b4.in_bcast = tbl[i].bc; b4.in_sel = tbl[i].sel;
      b4.in_data = tbl[i].dat; b4.out_ready = tbl[i].ordy;
      @(negedge clk);
      check($sformatf("tbl%0d_rdy", i), 32'(b4.in_ready), 32'(tbl[i].rdy));
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d_ov", i), 32'(b4.out_valid), 32'(tbl[i].ov));
      check($sformatf("tbl%0d_od", i), 32'(b4.out_data), tbl[i].od);
      check($sformatf("tbl%0d_err", i), 32'(b4.sel_err), 32'h0);
    end
    b4.in_valid = 1'b0; b4.in_bcast = 1'b0;

    // Out-of-range select on the N=3 instance: dropped, one-cycle error pulse.
    b3.in_valid = 1'b1; b3.in_sel = 2'd3; b3.in_data = 8'h7E;
    @(negedge clk);
    check("sel3_rdy", 32'(b3.in_ready), 32'h1);
    @(posedge clk);
    #1;
    b3.in_valid = 1'b0;
    check("sel3_ov", 32'(b3.out_valid), 32'h0);
    check("sel3_err1", 32'(b3.sel_err), 32'h1);
    @(posedge clk);
    #1;
    check("sel3_err2", 32'(b3.sel_err), 32'h0);
    check("sel3_ov2", 32'(b3.out_valid), 32'h0);

    // Fill channels 0 and 3 while stalled, then assert reset between clock edges.
    b4.out_ready = 4'b0110;
    b4.in_valid = 1'b1; b4.in_sel = 2'd0; b4.in_data = 8'h10;
    @(posedge clk);
    #1;
    b4.in_sel = 2'd3; b4.in_data = 8'h13;
    @(posedge clk);
    #1;
    b4.in_valid = 1'b0;
    check("stall_ov", 32'(b4.out_valid), 32'h9);
    check("stall_od", 32'(b4.out_data) & 32'hFF0000FF, 32'h13000010);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ov", 32'(b4.out_valid), 32'h0);
    check("arst_od", 32'(b4.out_data), 32'h0);
    check("arst_err", 32'(b4.sel_err), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    b4.in_valid = 1'b1; b4.in_sel = 2'd0; b4.in_data = 8'h99; b4.in_bcast = 1'b1;
    #1;
    check("post_rdy_bc", 32'(b4.in_ready), 32'h1);
    b4.in_bcast = 1'b0;
    #1;
    check("post_rdy_s0", 32'(b4.in_ready), 32'h1);
    @(posedge clk);
    #1;
    b4.in_valid = 1'b0;
    check("post_ov", 32'(b4.out_valid), 32'h1);
    check("post_od0", 32'(b4.out_data[0]), 32'h99);

    // Randomized traffic on both instances against the reference model.
    rst_n = 1'b0;
    b4.out_ready = '1; b3.out_ready = '1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    @(posedge clk);
    #1;
    for (int k = 0; k < 400; k++) begin
      b4.in_valid  = ($urandom_range(0, 3) != 0);
      b4.in_bcast  = ($urandom_range(0, 7) == 0);
      b4.in_sel    = 2'($urandom_range(0, 3));
      b4.in_data   = 8'($urandom);
      b4.out_ready = rnd_ready(4);
      b3.in_valid  = ($urandom_range(0, 3) != 0);
      b3.in_bcast  = ($urandom_range(0, 7) == 0);
      b3.in_sel    = 2'($urandom_range(0, 3));
      b3.in_data   = 8'($urandom);
      b3.out_ready = 3'(rnd_ready(3));
      @(negedge clk);
      check("rnd_rdy4", 32'(b4.in_ready),
            32'(m_ready(0, 4, b4.in_bcast, int'(b4.in_sel), b4.out_ready)));
      check("rnd_rdy3", 32'(b3.in_ready),
            32'(m_ready(1, 3, b3.in_bcast, int'(b3.in_sel), 4'(b3.out_ready))));
      @(posedge clk);
      #1;
      m_step(0, 4, b4.in_valid, b4.in_bcast, int'(b4.in_sel), b4.in_data, b4.out_ready);
      m_step(1, 3, b3.in_valid, b3.in_bcast, int'(b3.in_sel), b3.in_data, 4'(b3.out_ready));
      check("rnd_ov4", 32'(b4.out_valid), m_ov(0, 4));
      check("rnd_od4", 32'(b4.out_data), m_od(0, 4));
      check("rnd_err4", 32'(b4.sel_err), 32'(err[0]));
      check("rnd_ov3", 32'(b3.out_valid), m_ov(1, 3));
      check("rnd_od3", 32'(b3.out_data), m_od(1, 3));
      check("rnd_err3", 32'(b3.sel_err), 32'(err[1]));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/demux_1xn_stream.md
DEMUX_1XN_STREAM -- requirements
Module: demux_1xn_stream

Interface
REQ-001 Parameter WIDTH, default 2: payload width in bits, SHALL be >= 1.
REQ-002 Parameter N, default 4: output channel count, SHALL be >= 2; SELW = $clog2(N) SHALL be a derived localparam.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_data  input  WIDTH  payload.
REQ-006 in_sel  input  SELW  destination channel index.
REQ-007 in_bcast  input  1  broadcast request; when 1, in_sel SHALL be ignored.
REQ-008 in_valid  input  1  source holds a beat.
REQ-009 in_ready  output  1  block accepts the beat this cycle.
REQ-010 out_data  output  [N-1:0][WIDTH-1:0]  per-channel payload, packed, channel i at index i.
REQ-011 out_valid  output  N  per-channel valid.
REQ-012 out_ready  input  N  per-channel sink ready.
REQ-013 sel_err  output  1  one-cycle pulse flagging a dropped beat with in_sel >= N.

Function
REQ-014 Each channel i SHALL hold one registered slot (out_data[i], out_valid[i]).
REQ-015 can_load[i] = !out_valid[i] || out_ready[i]; a full slot being drained SHALL accept new data in the same cycle.
REQ-016 Accept = in_valid && in_ready; in_ready SHALL be combinational and SHALL NOT depend on in_valid.
REQ-017 Unicast (in_bcast=0, in_sel<N): in_ready = can_load[in_sel]; on accept, slot in_sel loads in_data and sets out_valid.
REQ-018 Broadcast (in_bcast=1): in_ready = AND of can_load[0..N-1]; on accept, every slot loads in_data and sets out_valid.
REQ-019 Invalid select (in_bcast=0, in_sel>=N, possible only for non-power-of-2 N): in_ready=1, beat discarded, no slot changes, sel_err=1 in the following cycle only.
REQ-020 Latency: beat accepted at edge k SHALL be visible on out_valid/out_data immediately after edge k.
REQ-021 Throughput: one beat per cycle to a channel whose out_ready is held 1.
REQ-022 out_valid[i] SHALL clear after an edge where out_valid[i] && out_ready[i] && slot i not loaded.
REQ-023 While out_valid[i] && !out_ready[i], out_data[i] SHALL remain stable.
REQ-024 Channels SHALL be independent: a stalled channel SHALL NOT block unicast traffic to other channels.
REQ-025 Broadcast SHALL be all-or-nothing: no partial delivery.

Reset
REQ-026 While rst_n=0: out_valid=0, out_data=0 for all channels, sel_err=0, regardless of clk.
REQ-027 Reset asserted mid-transfer SHALL discard all held beats; first cycle after release, in_ready=1 for any in_sel<N and for broadcast.

Configuration
REQ-028 Macro DEMUX_ZERO_IDLE_EN defined: out_data[i] SHALL read 0 whenever out_valid[i]=0 (slot data cleared on drain without reload).
REQ-029 Macro DEMUX_ZERO_IDLE_EN undefined: out_data[i] SHALL hold its last loaded value when out_valid[i]=0; no clearing logic.

Verification
REQ-030 N=4, WIDTH=8, all out_ready=1: send 0x11,0x22,0x33,0x44 with in_sel 0,1,2,3 on consecutive cycles -> each out_valid[i] high one cycle, data matches, in_ready=1 throughout.
REQ-031 N=4, out_ready[2]=0: beat 0xA5 to sel 2, then 0x5A to sel 2 -> first held stable on channel 2, in_ready=0 for second; raise out_ready[2] -> 0x5A loads same cycle 0xA5 drains.
REQ-032 N=4, out_ready[1]=0 holding a beat: broadcast 0xFF -> in_ready=0, no slot changes; release out_ready[1] -> all four channels present 0xFF one cycle later.
REQ-033 N=3: in_sel=3, in_data=0x7E -> in_ready=1, no out_valid, sel_err=1 for exactly one cycle.
REQ-034 Channels 0 and 3 full and stalled, assert rst_n=0 asynchronously -> out_valid=0000 and out_data=0 immediately; after release, beat to sel 0 accepted.
REQ-035 Run REQ-030 with and without DEMUX_ZERO_IDLE_EN -> idle out_data reads 0 only when defined, else last value (e.g. channel 0 holds 0x11).
